maxpool3x3_s2_stream: RTL and testbench

// Streaming 3x3 / stride-2 max-pool over a raster-ordered FP32 feature map (D x D, one channel).

---
 rtl/maxpool3x3_s2_stream.sv | 99 +++++++++
 tb/tb_maxpool3x3_s2_stream.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool3x3_s2_stream.sv
// rtl/maxpool3x3_s2_stream.sv - streaming 3x3 stride-2 FP32 max-pool over a raster-ordered D x D map
module maxpool3x3_s2_stream #(
    parameter int data_width = 32,
    parameter int D          = 35
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [data_width-1:0] pxl_in,
    output logic [data_width-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);
    localparam int OD  = (D - 3) / 2 + 1;
    localparam int CW  = $clog2(D);
    localparam int OCW = $clog2(OD * OD);

    localparam logic [CW-1:0]  LAST_POS = CW'(D - 1);
    localparam logic [OCW-1:0] LAST_OUT = OCW'(OD * OD - 1);

    logic [CW-1:0]  col_cnt;
    logic [CW-1:0]  row_cnt;
    logic [OCW-1:0] out_cnt;

    // lb_up1 holds row r-1, lb_up2 holds row r-2, both indexed by column
    logic [data_width-1:0] lb_up1 [D];
    logic [data_width-1:0] lb_up2 [D];
    // win[col][row]: col 0 is leftmost, row 0 is the upper row
    logic [data_width-1:0] win     [3][3];
    logic [data_width-1:0] col_max [3];

    logic win_valid;
    logic s1_valid;
    logic completes;

    // Sign-magnitude ordering; +0 and -0 are equal, so neither is greater
    function automatic logic fp_gt(input logic [data_width-1:0] a, input logic [data_width-1:0] b);
        if (a[data_width-2:0] == '0 && b[data_width-2:0] == '0)
            return 1'b0;
        if (a[data_width-1] != b[data_width-1])
            return !a[data_width-1];
        if (!a[data_width-1])
            return a[data_width-2:0] > b[data_width-2:0];
        return a[data_width-2:0] < b[data_width-2:0];
    endfunction

    // a is the earlier operand and wins ties
    function automatic logic [data_width-1:0] max2(input logic [data_width-1:0] a, input logic [data_width-1:0] b);
        return fp_gt(b, a) ? b : a;
    endfunction

    assign completes = (row_cnt >= CW'(2)) && (col_cnt >= CW'(2)) && !row_cnt[0] && !col_cnt[0];

    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb_up2[col_cnt] <= lb_up1[col_cnt];
            lb_up1[col_cnt] <= pxl_in;
            for (int r = 0; r < 3; r++) begin
                win[0][r] <= win[1][r];
                win[1][r] <= win[2][r];
            end
            win[2][0] <= lb_up2[col_cnt];
            win[2][1] <= lb_up1[col_cnt];
            win[2][2] <= pxl_in;
        end
        for (int c = 0; c < 3; c++)
            col_max[c] <= max2(max2(win[c][0], win[c][1]), win[c][2]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            out_cnt    <= '0;
            win_valid  <= 1'b0;
            s1_valid   <= 1'b0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            pxl_out    <= '0;
        end else begin
            win_valid  <= valid_in && completes;
            s1_valid   <= win_valid;
            valid_out  <= s1_valid;
            frame_done <= s1_valid && (out_cnt == LAST_OUT);
            if (s1_valid) begin
                pxl_out <= max2(max2(col_max[0], col_max[1]), col_max[2]);
                out_cnt <= (out_cnt == LAST_OUT) ? '0 : out_cnt + OCW'(1);
            end
            if (valid_in) begin
                if (col_cnt == LAST_POS) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == LAST_POS) ? '0 : row_cnt + CW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_maxpool3x3_s2_stream.sv
// tb/tb_maxpool3x3_s2_stream.sv - directed self-checking bench for maxpool3x3_s2_stream
module tb_maxpool3x3_s2_stream;
    localparam int D  = 35;
    localparam int OD = 17;
    localparam int NP = D * D;
    localparam int NO = OD * OD;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] pxl_in;
    logic [31:0] pxl_out;
    logic        valid_out;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] out_q[$];
    int          out_cyc[$];
    int          comp_cyc[$];
    int          fd_idx[$];
    int          fd_orphan = 0;

    maxpool3x3_s2_stream #(.data_width(32), .D(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .pxl_in    (pxl_in),
        .pxl_out   (pxl_out),
        .valid_out (valid_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out) begin
            out_q.push_back(pxl_out);
            out_cyc.push_back(cyc);
            if (frame_done) fd_idx.push_back(out_q.size() - 1);
        end else if (frame_done) begin
            fd_orphan++;
        end
    end

    function automatic logic [31:0] i2f(input int n);
        int          a;
        int          e;
        logic [31:0] m;
        a = (n < 0) ? -n : n;
        e = 0;
        for (int b = 0; b < 24; b++) if (a[b]) e = b;
        m = 32'(a) << (23 - e);
        return {(n < 0), 8'(127 + e), m[22:0]};
    endfunction

    function automatic logic [31:0] pix(input int kind, input int k);
        case (kind)
            0:       return i2f(k + 1);
            1:       return i2f(-(k + 1));
            2:       return (k == 36) ? 32'h3c23d70a : 32'hbf800000;
            default: return (k == 0) ? 32'h00000000 : 32'h80000000;
        endcase
    endfunction

    function automatic logic [31:0] expect_out(input int kind, input int o);
        int i;
        int j;
        i = o / OD;
        j = o % OD;
        case (kind)
            0:       return i2f((2 * i + 2) * D + 2 * j + 2 + 1);
            1:       return i2f(-((2 * i) * D + 2 * j + 1));
            2:       return (o == 0) ? 32'h3c23d70a : 32'hbf800000;
            default: return (o == 0) ? 32'h00000000 : 32'h80000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [31:0] v);
        @(negedge clk);
        valid_in = vld;
        pxl_in   = v;
    endtask

    task automatic send(input int kind, input int npix, input bit gaps);
        int k;
        int slot;
        k = 0;
        slot = 0;
        while (k < npix) begin
            slot++;
            if (gaps && (slot % 3 == 0)) begin
                drive(1'b0, 32'hdeadbeef);
            end else begin
                drive(1'b1, pix(kind, k));
                if ((k / D) >= 2 && (k % D) >= 2 && (k / D) % 2 == 0 && (k % D) % 2 == 0)
                    comp_cyc.push_back(cyc + 1);
                k++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0);
    endtask

    task automatic clear_logs();
        out_q.delete();
        out_cyc.delete();
        comp_cyc.delete();
        fd_idx.delete();
        fd_orphan = 0;
    endtask

    task automatic check_vals(input string tag, input int kind, input int base);
        logic [31:0] obs;
        for (int o = 0; o < NO; o++) begin
            obs = (base + o < out_q.size()) ? out_q[base + o] : 32'hxxxxxxxx;
            chk($sformatf("%s_out%0d", tag, o), obs, expect_out(kind, o));
        end
    endtask

    task automatic check_latency(input string tag);
        for (int o = 0; o < NO; o++) begin
            if (o < out_cyc.size() && o < comp_cyc.size())
                chk($sformatf("%s_lat%0d", tag, o), 32'(out_cyc[o]), 32'(comp_cyc[o] + 2));
        end
    endtask

    task automatic check_frame_marks(input string tag, input int nframes);
        chk({tag, "_count"}, 32'(out_q.size()), 32'(nframes * NO));
        chk({tag, "_fd_count"}, 32'(fd_idx.size()), 32'(nframes));
        chk({tag, "_fd_orphan"}, 32'(fd_orphan), 32'd0);
        for (int f = 0; f < nframes; f++)
            chk($sformatf("%s_fd_pos%0d", tag, f),
                (f < fd_idx.size()) ? 32'(fd_idx[f]) : 32'hffffffff, 32'((f + 1) * NO - 1));
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        pxl_in   = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_pxl_out", pxl_out, 32'd0);
        reset = 1'b1;
        idle(2);

        // T1 positive ramp
        clear_logs();
        send(0, NP, 1'b0);
        idle(6);
        check_frame_marks("t1", 1);
        check_vals("t1", 0, 0);
        check_latency("t1");
        chk("t1_first", (out_q.size() > 0) ? out_q[0] : 32'hx, i2f(73));
        chk("t1_hold", pxl_out, i2f(1225));

        // T2 negative ramp
        clear_logs();
        send(1, NP, 1'b0);
        idle(6);
        check_frame_marks("t2", 1);
        check_vals("t2", 1, 0);
        chk("t2_first", (out_q.size() > 0) ? out_q[0] : 32'hx, 32'hbf800000);

        // T3 mixed signs
        clear_logs();
        send(2, NP, 1'b0);
        idle(6);
        check_frame_marks("t3", 1);
        check_vals("t3", 2, 0);

        // T4 gaps every third cycle
        clear_logs();
        send(0, NP, 1'b1);
        idle(6);
        check_frame_marks("t4", 1);
        check_vals("t4", 0, 0);
        check_latency("t4");

        // T5 reset mid-frame then a full frame
        send(0, 600, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        reset    = 1'b0;
        clear_logs();
        #1;
        chk("t5_rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("t5_rst_pxl_out", pxl_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        send(0, NP, 1'b0);
        idle(6);
        check_frame_marks("t5", 1);
        check_vals("t5", 0, 0);
        check_latency("t5");

        // T6 zero tie frame immediately followed by a ramp frame
        clear_logs();
        send(3, NP, 1'b0);
        send(0, NP, 1'b0);
        idle(6);
        check_frame_marks("t6", 2);
        check_vals("t6a", 3, 0);
        check_vals("t6b", 0, NO);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
